// File: rtl/dht11_frame_checker_if.sv
// Frame-in / validated-sample-out bundle between the DHT11 reader and its consumers.
// Optional min/max tracking signals exist only when DHT_MINMAX_EN is defined.
interface dht11_frame_checker_if #(
   parameter int unsigned ERR_W = 8
);
   logic [39:0]      tem_hum;
   logic [7:0]       hum_int;
   logic [7:0]       hum_dec;
   logic [7:0]       temp_int;
   logic [7:0]       temp_dec;
   logic             data_valid;
   logic             new_sample;
   logic             temp_alarm;
   logic             hum_alarm;
   logic [ERR_W-1:0] crc_err_cnt;
`ifdef DHT_MINMAX_EN
   logic [7:0]       temp_min;
   logic [7:0]       temp_max;
   logic [7:0]       hum_min;
   logic [7:0]       hum_max;

   modport master (
      output tem_hum,
      input  hum_int, hum_dec, temp_int, temp_dec, data_valid, new_sample,
             temp_alarm, hum_alarm, crc_err_cnt, temp_min, temp_max, hum_min, hum_max
   );
   modport slave (
      input  tem_hum,
      output hum_int, hum_dec, temp_int, temp_dec, data_valid, new_sample,
             temp_alarm, hum_alarm, crc_err_cnt, temp_min, temp_max, hum_min, hum_max
   );
`else
   modport master (
      output tem_hum,
      input  hum_int, hum_dec, temp_int, temp_dec, data_valid, new_sample,
             temp_alarm, hum_alarm, crc_err_cnt
   );
   modport slave (
      input  tem_hum,
      output hum_int, hum_dec, temp_int, temp_dec, data_valid, new_sample,
             temp_alarm, hum_alarm, crc_err_cnt
   );
`endif
endinterface

// File: rtl/dht11_frame_checker.sv
// Settles the DHT11 40-bit frame, verifies its checksum and publishes values, alarms and error count.
// Define DHT_MINMAX_EN to add running min/max tracking of the integer bytes.
module dht11_frame_checker #(
   parameter int unsigned SETTLE_CYC = 16,
   parameter logic [7:0]  TEMP_HI    = 8'd35,
   parameter logic [7:0]  HUM_HI     = 8'd80,
   parameter logic [7:0]  HYST       = 8'd3,
   parameter int unsigned ERR_W      = 8
) (
   input logic                  clk_50m,
   input logic                  rst,
   dht11_frame_checker_if.slave bus
);
   localparam int unsigned    CNT_W    = $clog2(SETTLE_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   typedef enum logic [1:0] {IDLE, SETTLE, CHECK} state_t;

   state_t           state;
   logic [39:0]      last_seen;
   logic [39:0]      cand;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       sum;
   logic             frame_ok;

   always_comb begin
      sum      = cand[39:32] + cand[31:24] + cand[23:16] + cand[15:8];
      frame_ok = (sum == cand[7:0]) && (cand != '0);
   end

   function automatic logic alarm_next(input logic cur, input logic [7:0] v, input logic [7:0] hi);
      if (v >= hi)
         return 1'b1;
      else if (v < hi - HYST)
         return 1'b0;
      return cur;
   endfunction

   // NOTE: all state and outputs are assigned with <= so every read in this block sees pre-edge values.
   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         last_seen       <= '0;
         cand            <= '0;
         cnt             <= '0;
         bus.hum_int     <= '0;
         bus.hum_dec     <= '0;
         bus.temp_int    <= '0;
         bus.temp_dec    <= '0;
         bus.data_valid  <= 1'b0;
         bus.new_sample  <= 1'b0;
         bus.temp_alarm  <= 1'b0;
         bus.hum_alarm   <= 1'b0;
         bus.crc_err_cnt <= '0;
`ifdef DHT_MINMAX_EN
         bus.temp_min    <= 8'hFF;
         bus.temp_max    <= 8'h00;
         bus.hum_min     <= 8'hFF;
         bus.hum_max     <= 8'h00;
`endif
      end else begin
         bus.new_sample <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.tem_hum != last_seen) begin
                  cand  <= bus.tem_hum;
                  cnt   <= '0;
                  state <= SETTLE;
               end
            end
            SETTLE: begin
               if (bus.tem_hum != cand) begin
                  cand <= bus.tem_hum;
                  cnt  <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= CHECK;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            CHECK: begin
               state     <= IDLE;
               last_seen <= cand;
               // A glitch that settles back onto the last checked frame is neither re-published nor counted.
               if (cand != last_seen) begin
                  if (frame_ok) begin
                     bus.hum_int    <= cand[39:32];
                     bus.hum_dec    <= cand[31:24];
                     bus.temp_int   <= cand[23:16];
                     bus.temp_dec   <= cand[15:8];
                     bus.data_valid <= 1'b1;
                     bus.new_sample <= 1'b1;
                     bus.temp_alarm <= alarm_next(bus.temp_alarm, cand[23:16], TEMP_HI);
                     bus.hum_alarm  <= alarm_next(bus.hum_alarm, cand[39:32], HUM_HI);
`ifdef DHT_MINMAX_EN
                     if (cand[23:16] < bus.temp_min) bus.temp_min <= cand[23:16];
                     if (cand[23:16] > bus.temp_max) bus.temp_max <= cand[23:16];
                     if (cand[39:32] < bus.hum_min)  bus.hum_min  <= cand[39:32];
                     if (cand[39:32] > bus.hum_max)  bus.hum_max  <= cand[39:32];
`endif
                  end else if (cand != '0 && bus.crc_err_cnt != ERR_MAX) begin
                     bus.crc_err_cnt <= bus.crc_err_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dht11_frame_checker.sv
// Directed bench for dht11_frame_checker: a reference model pushes expected samples to a
// scoreboard queue that is popped on every new_sample pulse.
module tb_dht11_frame_checker;
   localparam int SETTLE = 16;
   localparam int T_HI   = 30;
   localparam int H_HI   = 80;
   localparam int HYST   = 2;
   localparam int ERR_W  = 8;
   localparam int ERR_SAT = (1 << ERR_W) - 1;
   localparam int WIN    = SETTLE + 6;

   typedef struct packed {
      logic [7:0] hi;
      logic [7:0] hd;
      logic [7:0] ti;
      logic [7:0] td;
      logic       ta;
      logic       ha;
   } rec_t;

   logic clk_50m = 1'b0;
   logic rst     = 1'b1;

   dht11_frame_checker_if #(.ERR_W(ERR_W)) bus();

   dht11_frame_checker #(
      .SETTLE_CYC(SETTLE),
      .TEMP_HI   (8'(T_HI)),
      .HUM_HI    (8'(H_HI)),
      .HYST      (8'(HYST)),
      .ERR_W     (ERR_W)
   ) dut (
      .clk_50m(clk_50m),
      .rst    (rst),
      .bus    (bus)
   );

   always #10 clk_50m = ~clk_50m;

   int          n_checks = 0;
   int          n_fail   = 0;
   rec_t        sb[$];
   rec_t        m_rec;
   logic [39:0] m_last;
   int          m_err;
   logic        m_valid;
   logic        exp_pulse;
   int          n_pulse;
   int          first_at;
`ifdef DHT_MINMAX_EN
   int m_tmin, m_tmax, m_hmin, m_hmax;
`endif

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic next_alarm(input logic cur, input int v, input int hi);
      if (v >= hi) return 1'b1;
      if (v < hi - HYST) return 1'b0;
      return cur;
   endfunction

   task automatic model_reset();
      m_rec   = '0;
      m_last  = '0;
      m_err   = 0;
      m_valid = 1'b0;
      sb.delete();
`ifdef DHT_MINMAX_EN
      m_tmin = 255; m_tmax = 0; m_hmin = 255; m_hmax = 0;
`endif
   endtask

   task automatic model_apply(input logic [39:0] f);
      int s, h, t;
      exp_pulse = 1'b0;
      if (f == m_last) return;
      m_last = f;
      h = int'(f[39:32]);
      t = int'(f[23:16]);
      s = (h + int'(f[31:24]) + t + int'(f[15:8])) % 256;
      if (f != 40'h0 && s == int'(f[7:0])) begin
         m_rec.hi = f[39:32];
         m_rec.hd = f[31:24];
         m_rec.ti = f[23:16];
         m_rec.td = f[15:8];
         m_rec.ta = next_alarm(m_rec.ta, t, T_HI);
         m_rec.ha = next_alarm(m_rec.ha, h, H_HI);
         sb.push_back(m_rec);
         m_valid   = 1'b1;
         exp_pulse = 1'b1;
`ifdef DHT_MINMAX_EN
         if (t < m_tmin) m_tmin = t;
         if (t > m_tmax) m_tmax = t;
         if (h < m_hmin) m_hmin = h;
         if (h > m_hmax) m_hmax = h;
`endif
      end else if (f != 40'h0 && m_err < ERR_SAT) begin
         m_err++;
      end
   endtask

   task automatic drive(input logic [39:0] f);
      bus.tem_hum = f;
      model_apply(f);
   endtask

   // Steps n cycles; every new_sample pulse is compared against the scoreboard head.
   task automatic observe(input int n);
      rec_t got, exp;
      n_pulse  = 0;
      first_at = -1;
      for (int i = 1; i <= n; i++) begin
         @(posedge clk_50m);
         #1;
         if (bus.new_sample === 1'b1) begin
            n_pulse++;
            if (first_at < 0) first_at = i;
            got = '{bus.hum_int, bus.hum_dec, bus.temp_int, bus.temp_dec, bus.temp_alarm, bus.hum_alarm};
            check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
               exp = sb.pop_front();
               check("sample", 64'(got), 64'(exp));
            end
         end
      end
   endtask

   task automatic check_frame(input string tag);
      check({tag, "_pulses"}, 64'(n_pulse), 64'(exp_pulse));
      if (exp_pulse) check({tag, "_latency"}, 64'(first_at), 64'(SETTLE + 2));
      check({tag, "_vals"}, {32'h0, bus.hum_int, bus.hum_dec, bus.temp_int, bus.temp_dec},
            {32'h0, m_rec.hi, m_rec.hd, m_rec.ti, m_rec.td});
      check({tag, "_alarms"}, 64'({bus.temp_alarm, bus.hum_alarm}), 64'({m_rec.ta, m_rec.ha}));
      check({tag, "_valid"}, 64'(bus.data_valid), 64'(m_valid));
      check({tag, "_crc"}, 64'(bus.crc_err_cnt), 64'(m_err));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_vals"}, {32'h0, bus.hum_int, bus.hum_dec, bus.temp_int, bus.temp_dec}, 64'h0);
      check({tag, "_flags"}, 64'({bus.data_valid, bus.new_sample, bus.temp_alarm, bus.hum_alarm}), 64'h0);
      check({tag, "_crc"}, 64'(bus.crc_err_cnt), 64'h0);
`ifdef DHT_MINMAX_EN
      check({tag, "_minmax"}, 64'({bus.temp_min, bus.temp_max, bus.hum_min, bus.hum_max}),
            64'(32'hFF00_FF00));
`endif
   endtask

   logic [39:0] hyst_f [4] = '{40'h32001E0050, 40'h32001D004F, 40'h32001C004E, 40'h32001B004D};
   logic        hyst_ta[4] = '{1'b1, 1'b1, 1'b1, 1'b0};

   initial begin
      int tot;
      bus.tem_hum = '0;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk_50m);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      observe(2);

      // Good frame: 60 %RH, 25 C
      drive(40'h3C00190055);
      observe(WIN);
      check_frame("good");
      check("good_hum", 64'(bus.hum_int), 64'(60));
      check("good_temp", 64'(bus.temp_int), 64'(25));

      // Bad checksum keeps the previous values
      drive(40'h3C00190056);
      observe(WIN);
      check_frame("badcrc");

      // Return to a good frame, then glitch away and back
      drive(40'h3C00190055);
      observe(WIN);
      check_frame("good2");
      bus.tem_hum = 40'h4100190000;
      observe(5);
      check("glitch_win_pulses", 64'(n_pulse), 64'(0));
      drive(40'h3C00190055);
      observe(WIN);
      check_frame("glitch");

      // Bad frame held: exactly one increment
      drive(40'h4100190000);
      observe(WIN);
      check_frame("held_bad");
      observe(WIN);
      check("held_bad_nopulse", 64'(n_pulse), 64'(0));
      check("held_bad_crc", 64'(bus.crc_err_cnt), 64'(m_err));

      // Temperature hysteresis around TEMP_HI=30, HYST=2
      for (int i = 0; i < 4; i++) begin
         drive(hyst_f[i]);
         observe(WIN);
         check_frame("hyst");
         check("hyst_temp_alarm", 64'(bus.temp_alarm), 64'(hyst_ta[i]));
      end

      // Humidity alarm set
      drive(40'h55001B0070);
      observe(WIN);
      check_frame("hum_alarm");
      check("hum_alarm_set", 64'(bus.hum_alarm), 64'(1));

      // Error counter saturation with 300 distinct bad frames
      tot = 0;
      for (int i = 1; i <= 300; i++) begin
         drive({16'(i), 16'h0, 8'(i[15:8] + i[7:0] + 8'd1)});
         observe(SETTLE + 3);
         tot += n_pulse;
      end
      check("sat_pulses", 64'(tot), 64'(0));
      check("sat_crc", 64'(bus.crc_err_cnt), 64'(ERR_SAT));
      check("sat_model", 64'(m_err), 64'(255));

      // All-zero frame: rejected silently
      drive(40'h0);
      observe(WIN);
      check_frame("zero");

      // Reset in the 5th SETTLE cycle, then full re-settle
      drive(40'h3C00190055);
      repeat (5) @(posedge clk_50m);
      #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      repeat (2) @(posedge clk_50m);
      #1;
      check_reset_outputs("midrst_hold");
      rst = 1'b0;
      model_reset();
      model_apply(40'h3C00190055);
      observe(WIN);
      check_frame("post_rst");
`ifdef DHT_MINMAX_EN
      check("post_rst_minmax", 64'({bus.temp_min, bus.temp_max, bus.hum_min, bus.hum_max}),
            64'({8'(m_tmin), 8'(m_tmax), 8'(m_hmin), 8'(m_hmax)}));
      check("post_rst_minmax_const", 64'({bus.temp_min, bus.temp_max, bus.hum_min, bus.hum_max}),
            64'(32'h1919_3C3C));
`endif
      check("sb_drained", 64'(sb.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
